axil_regfile_slave: RTL
=======================

AXIL_REGFILE_SLAVE -- requirements
Module: axil_regfile_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: byte-address width of AW_ADDR and AR_ADDR.
REQ-002 Parameter DATA_WIDTH, default 32: data width, one of 32 or 64; strobe width is DATA_WIDTH/8.
REQ-003 Parameter DEPTH, default 64: number of DATA_WIDTH words stored, at most 2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
REQ-004 Ports, in order: clock and reset, then the AXI-Lite slave channels.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- AW_ADDR  in  ADDR_WIDTH  write byte address.
- AW_PROT  in  3  accepted and ignored.
- AW_VALID  in  1  write address valid.
- AW_READY  out  1  write address ready.
- W_DATA  in  DATA_WIDTH  write data.
- W_STRB  in  DATA_WIDTH/8  byte-lane write enables.
- W_VALID  in  1  write data valid.
- W_READY  out  1  write data ready.
- B_RESP  out  2  write response (00 OKAY, 10 SLVERR).
- B_valid  out  1  write response valid.
- B_ready  in  1  write response ready.
- AR_ADDR  in  ADDR_WIDTH  read byte address.
- AR_PROT  in  3  accepted and ignored.
- AR_VALID  in  1  read address valid.
- AR_READY  out  1  read address ready.
- R_DATA  out  DATA_WIDTH  read data.
- R_RESP  out  2  read response.
- R_VALID  out  1  read data valid.
- R_READY  in  1  read data ready.

Function
REQ-005 Word index = byte address >> log2(DATA_WIDTH/8); low byte-offset bits are ignored, with no error for unaligned addresses.
REQ-006 The AW and W channels are decoupled, each with a one-entry holding register.
- AW_READY = AW holding register empty.
- W_READY = W holding register empty.
- AW and W may arrive in either order or in the same cycle.
REQ-007 A write commits in any cycle where both holding registers are full and B_valid is 0.
- Only byte lanes with W_STRB set are updated.
- Both holding registers are freed in the same cycle.
- B_valid rises on the next edge.
REQ-008 B_valid and B_RESP stay stable until the cycle B_valid && B_ready; B_valid clears on that edge.
REQ-009 A new AW/W pair may be captured while B_valid is high, but it does not commit until B_valid has cleared.
REQ-010 Read path:
- AR_READY = !R_VALID.
- On the AR handshake, R_DATA and R_RESP are registered and R_VALID rises on the next edge (1-cycle latency).
- R_DATA, R_RESP and R_VALID hold until R_VALID && R_READY.
REQ-011 A read handshake in the same cycle as a write commit to the same word returns the pre-write data.
REQ-012 The read and write paths operate concurrently and independently; neither stalls the other.
REQ-013 Maximum throughput:
- Reads: one accepted every 2 cycles.
- Writes: one accepted every 2 cycles with B_ready held high.

Reset
REQ-014 While rst = 1, all of the following are 0 on the next edge: AW_READY, W_READY, B_valid, B_RESP, AR_READY, R_VALID, R_RESP, R_DATA.
REQ-015 While rst = 1, both holding registers are emptied and every storage word is cleared to 0.
REQ-016 A reset asserted mid-transaction discards the pending AW, W, B and R state with no response issued.
REQ-017 After rst deasserts, AW_READY, W_READY and AR_READY assert on the first edge.

Configuration
REQ-018 Macro AXIL_REGFILE_SLVERR_EN, when defined:
- A word index >= DEPTH returns SLVERR (10).
- A write to such an index updates no storage.
- A read from such an index returns R_DATA = 0.
REQ-019 Without AXIL_REGFILE_SLVERR_EN, the word index is taken modulo DEPTH and all responses are OKAY (00).

Verification
REQ-020 Write 0x0000_0004 to 0x004 with full strobe, then read 0x004 -> B_RESP 00; R_DATA 0x0000_0004; R_RESP 00.
REQ-021 W (0xAABB_CCDD, strb 1111) presented 3 cycles before AW 0x010 -> W_READY low after capture; single commit; a read of 0x010 returns 0xAABB_CCDD.
REQ-022 Word 0x020 holds 0x1122_3344; write 0xFFFF_FFFF with strb 0101 -> a read of 0x020 returns 0x11FF_33FF.
REQ-023 Hold B_ready low for 5 cycles after a write -> B_valid stays high and B_RESP stays stable; a second AW/W pair is captured but commits only after the B handshake.
REQ-024 Address 0x200 with DEPTH 64:
- With macro: write returns 10; read returns 10 with R_DATA 0.
- Without macro: write and read alias word 0 with OKAY.
REQ-025 Assert rst while R_VALID is high with R_READY low -> R_VALID is 0 on the next edge, and a read of any address returns 0.

Source files
------------

// File: rtl/axil_regfile_slave.sv
// AXI-Lite slave register file: DEPTH words of DATA_WIDTH bits with byte strobes.
// Define AXIL_REGFILE_SLVERR_EN to answer SLVERR for word indices >= DEPTH instead of wrapping them.
module axil_regfile_slave #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   AW_ADDR,
   input  logic [2:0]              AW_PROT,
   input  logic                    AW_VALID,
   output logic                    AW_READY,
   input  logic [DATA_WIDTH-1:0]   W_DATA,
   input  logic [DATA_WIDTH/8-1:0] W_STRB,
   input  logic                    W_VALID,
   output logic                    W_READY,
   output logic [1:0]              B_RESP,
   output logic                    B_valid,
   input  logic                    B_ready,
   input  logic [ADDR_WIDTH-1:0]   AR_ADDR,
   input  logic [2:0]              AR_PROT,
   input  logic                    AR_VALID,
   output logic                    AR_READY,
   output logic [DATA_WIDTH-1:0]   R_DATA,
   output logic [1:0]              R_RESP,
   output logic                    R_VALID,
   input  logic                    R_READY
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned OFFS   = $clog2(STRB_W);
   localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic                  r_live;
   logic                  r_aw_full;
   logic [ADDR_WIDTH-1:0] r_aw_addr;
   logic                  r_w_full;
   logic [DATA_WIDTH-1:0] r_w_data;
   logic [STRB_W-1:0]     r_w_strb;
   logic                  r_b_valid;
   logic [1:0]            r_b_resp;
   logic                  r_r_valid;
   logic [DATA_WIDTH-1:0] r_r_data;
   logic [1:0]            r_r_resp;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_ar_hs;
   logic                  w_b_hs;
   logic                  w_r_hs;
   logic                  w_commit;
   logic [ADDR_WIDTH-1:0] w_aw_word;
   logic [ADDR_WIDTH-1:0] w_ar_word;
   logic [IDX_W-1:0]      w_aw_idx;
   logic [IDX_W-1:0]      w_ar_idx;
   logic                  w_aw_err;
   logic                  w_ar_err;
   logic                  w_unused;

   // r_live keeps all ready signals low until the first edge after reset
   assign AW_READY = r_live & ~r_aw_full;
   assign W_READY  = r_live & ~r_w_full;
   assign AR_READY = r_live & ~r_r_valid;
   assign B_valid  = r_b_valid;
   assign B_RESP   = r_b_resp;
   assign R_VALID  = r_r_valid;
   assign R_DATA   = r_r_data;
   assign R_RESP   = r_r_resp;

   assign w_aw_hs  = AW_VALID & AW_READY;
   assign w_w_hs   = W_VALID & W_READY;
   assign w_ar_hs  = AR_VALID & AR_READY;
   assign w_b_hs   = r_b_valid & B_ready;
   assign w_r_hs   = r_r_valid & R_READY;
   assign w_commit = r_aw_full & r_w_full & ~r_b_valid;

   assign w_aw_word = r_aw_addr >> OFFS;
   assign w_ar_word = AR_ADDR >> OFFS;
   assign w_aw_idx  = IDX_W'(w_aw_word % DEPTH_A);
   assign w_ar_idx  = IDX_W'(w_ar_word % DEPTH_A);

`ifdef AXIL_REGFILE_SLVERR_EN
   assign w_aw_err = (w_aw_word >= DEPTH_A);
   assign w_ar_err = (w_ar_word >= DEPTH_A);
`else
   assign w_aw_err = 1'b0;
   assign w_ar_err = 1'b0;
`endif

   assign w_unused = &{1'b0, AW_PROT, AR_PROT};

   // Holding registers, write response and read response channels
   always_ff @(posedge clk) begin
      if (rst) begin
         r_live    <= 1'b0;
         r_aw_full <= 1'b0;
         r_aw_addr <= '0;
         r_w_full  <= 1'b0;
         r_w_data  <= '0;
         r_w_strb  <= '0;
         r_b_valid <= 1'b0;
         r_b_resp  <= RESP_OKAY;
         r_r_valid <= 1'b0;
         r_r_data  <= '0;
         r_r_resp  <= RESP_OKAY;
      end else begin
         r_live <= 1'b1;

         if (w_aw_hs) begin
            r_aw_full <= 1'b1;
            r_aw_addr <= AW_ADDR;
         end else if (w_commit) begin
            r_aw_full <= 1'b0;
         end

         if (w_w_hs) begin
            r_w_full <= 1'b1;
            r_w_data <= W_DATA;
            r_w_strb <= W_STRB;
         end else if (w_commit) begin
            r_w_full <= 1'b0;
         end

         if (w_commit) begin
            r_b_valid <= 1'b1;
            r_b_resp  <= w_aw_err ? RESP_SLVERR : RESP_OKAY;
         end else if (w_b_hs) begin
            r_b_valid <= 1'b0;
         end

         // Storage is updated with <=, so a same-edge commit is not visible here
         if (w_ar_hs) begin
            r_r_valid <= 1'b1;
            r_r_data  <= w_ar_err ? '0 : r_mem[w_ar_idx];
            r_r_resp  <= w_ar_err ? RESP_SLVERR : RESP_OKAY;
         end else if (w_r_hs) begin
            r_r_valid <= 1'b0;
         end
      end
   end

   // Word storage with per-byte-lane write enables
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[IDX_W'(i)] <= '0;
         end
      end else if (w_commit && !w_aw_err) begin
         for (int unsigned b = 0; b < STRB_W; b++) begin
            if (r_w_strb[b]) begin
               r_mem[w_aw_idx][b*8 +: 8] <= r_w_data[b*8 +: 8];
            end
         end
      end
   end

endmodule
